mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for one shared memory port, one access in flight at a time.
// IDLE -> BUSY until mem_ready_i or timeout -> DONE (one-cycle ack) -> IDLE.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic [31:0] addr0_i,
   input  logic [31:0] addr1_i,
   input  logic        we0_i,
   input  logic        we1_i,
   input  logic [31:0] wdata0_i,
   input  logic [31:0] wdata1_i,
   output logic        ack0_o,
   output logic        ack1_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        sel_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_sel;
   logic        r_last;
   logic        r_we;
   logic        r_err;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [7:0]  r_cnt;
   logic        w_grant_vld;
   logic        w_grant_sel;
   logic        w_timeout;

   // On contention the port that did not win last time is served.
   assign w_grant_vld = req0_i | req1_i;
   assign w_grant_sel = (req0_i & req1_i) ? ~r_last : req1_i;
   assign w_timeout   = (r_cnt == LP_CNT_LAST) & ~mem_ready_i;

   always_comb begin
      w_next      = r_state;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      ack0_o      = 1'b0;
      ack1_o      = 1'b0;
      err_o       = 1'b0;
      busy_o      = 1'b0;
      mem_addr_o  = r_addr;
      mem_wdata_o = r_wdata;
      rdata_o     = r_rdata;
      sel_o       = r_sel;
      case (r_state)
         S_IDLE: begin
            if (w_grant_vld) w_next = S_BUSY;
         end
         S_BUSY: begin
            mem_req_o = 1'b1;
            mem_we_o  = r_we;
            busy_o    = 1'b1;
            if (mem_ready_i || w_timeout) w_next = S_DONE;
         end
         S_DONE: begin
            busy_o = 1'b1;
            ack0_o = ~r_sel;
            ack1_o = r_sel;
            err_o  = r_err;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_sel   <= w_grant_sel;
                  r_last  <= w_grant_sel;
                  r_addr  <= w_grant_sel ? addr1_i : addr0_i;
                  r_we    <= w_grant_sel ? we1_i : we0_i;
                  r_wdata <= w_grant_sel ? wdata1_i : wdata0_i;
                  r_cnt   <= 8'd0;
                  r_err   <= 1'b0;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + 8'd1;
               // A ready arriving on the last allowed cycle still counts as success.
               if (mem_ready_i) begin
                  r_rdata <= mem_rdata_i;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
